smallseg_g0_chain_walker: RTL and testbench

//  Upstream sequencer for one small-segment/G0 lookup table. Accepts a packet tuple and a chain head index.

---
 rtl/smallseg_g0_chain_walker_if.sv | 33 +++
 rtl/smallseg_g0_chain_walker.sv | 93 +++++++++
 tb/tb_smallseg_g0_chain_walker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/smallseg_g0_chain_walker_if.sv
// smallseg_g0_chain_walker_if: packet, update, result and table-port signals of the chain walker.
interface smallseg_g0_chain_walker_if #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int PACKET_BIT_LEN   = 104,
  parameter int ENTRY_DATA_WIDTH = 171
);
  logic                        pkt_valid, pkt_ready;
  logic [PACKET_BIT_LEN-1:0]   pkt_tuple;
  logic [INDEX_BIT_LEN-1:0]    pkt_head;
  logic                        upd_valid, upd_ready;
  logic [INDEX_BIT_LEN-1:0]    upd_index;
  logic [ENTRY_DATA_WIDTH-1:0] upd_data;
  logic                        res_valid, res_ready, res_match, res_overflow;
  logic [INDEX_BIT_LEN-1:0]    res_ruleID;
  logic [INDEX_BIT_LEN-1:0]    tbl_search_index;
  logic [PACKET_BIT_LEN-1:0]   tbl_tupleData;
  logic                        tbl_we;
  logic [ENTRY_DATA_WIDTH-1:0] tbl_din;
  logic                        tbl_match;
  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID, tbl_next_index;
  modport master (
    input  pkt_valid, pkt_tuple, pkt_head, upd_valid, upd_index, upd_data, res_ready,
           tbl_match, tbl_ruleID, tbl_next_index,
    output pkt_ready, upd_ready, res_valid, res_match, res_ruleID, res_overflow,
           tbl_search_index, tbl_tupleData, tbl_we, tbl_din
  );
  modport slave (
    output pkt_valid, pkt_tuple, pkt_head, upd_valid, upd_index, upd_data, res_ready,
           tbl_match, tbl_ruleID, tbl_next_index,
    input  pkt_ready, upd_ready, res_valid, res_match, res_ruleID, res_overflow,
           tbl_search_index, tbl_tupleData, tbl_we, tbl_din
  );
endinterface

// File: rtl/smallseg_g0_chain_walker.sv
// smallseg_g0_chain_walker: walks one G0 table chain per packet keeping the lowest matching ruleID, and serialises table writes.
// Optional macro CHAIN_EARLY_EXIT_EN: stop at the first match (chains stored priority-ordered).
module smallseg_g0_chain_walker #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int PACKET_BIT_LEN   = 104,
  parameter int ENTRY_DATA_WIDTH = 171,
  parameter int NULL_INDEX       = 2047,
  parameter int MAX_HOPS         = 16
) (
  input logic clk,
  input logic rst_n,
  smallseg_g0_chain_walker_if.master bus
);
  localparam int HW = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;
  localparam logic [INDEX_BIT_LEN-1:0] NULL_IDX = INDEX_BIT_LEN'(NULL_INDEX);
`ifdef CHAIN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [INDEX_BIT_LEN-1:0]    cur_idx, best, upd_idx;
  logic [PACKET_BIT_LEN-1:0]   tuple;
  logic [ENTRY_DATA_WIDTH-1:0] upd_dat;
  logic [HW-1:0]               hop_cnt;
  logic hit, ovf, upd_acc, pkt_acc, take, at_end, last, walking;
  always_comb begin
    upd_acc  = state == IDLE && bus.upd_valid;
    pkt_acc  = state == IDLE && !bus.upd_valid && bus.pkt_valid;
    take     = state == WAIT && bus.tbl_match && (EARLY || bus.tbl_ruleID < best);
    at_end   = bus.tbl_next_index == NULL_IDX || (EARLY && bus.tbl_match);
    last     = hop_cnt == HW'(MAX_HOPS - 1);
    walking  = state == ISSUE || state == WAIT;
    state_nx = state;
    case (state)
      IDLE:    state_nx = upd_acc ? WRITE : pkt_acc ? (bus.pkt_head == NULL_IDX ? DONE : ISSUE) : IDLE;
      WRITE:   state_nx = IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (at_end || last) ? DONE : ISSUE;
      DONE:    state_nx = bus.res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Readiness is gated by rst_n so both stay low while reset is held.
  assign bus.pkt_ready        = rst_n && state == IDLE && !bus.upd_valid;
  assign bus.upd_ready        = rst_n && state == IDLE;
  assign bus.res_valid        = state == DONE;
  assign bus.res_match        = hit;
  assign bus.res_ruleID       = best;
  assign bus.res_overflow     = ovf;
  assign bus.tbl_we           = state == WRITE;
  assign bus.tbl_search_index = state == WRITE ? upd_idx : walking ? cur_idx : '0;
  assign bus.tbl_tupleData    = walking ? tuple : '0;
  assign bus.tbl_din          = state == WRITE ? upd_dat : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cur_idx <= '0;
      best    <= '1;
      hit     <= 1'b0;
      ovf     <= 1'b0;
      hop_cnt <= '0;
      tuple   <= '0;
      upd_idx <= '0;
      upd_dat <= '0;
    end else begin
      state <= state_nx;
      if (upd_acc) begin
        upd_idx <= bus.upd_index;
        upd_dat <= bus.upd_data;
      end
      if (pkt_acc) begin
        tuple   <= bus.pkt_tuple;
        cur_idx <= bus.pkt_head;
        best    <= '1;
        hit     <= 1'b0;
        ovf     <= 1'b0;
        hop_cnt <= '0;
      end
      if (take) begin
        best <= bus.tbl_ruleID;
        hit  <= 1'b1;
      end
      if (state == WAIT && !at_end) begin
        if (last) ovf <= 1'b1;
        else begin
          cur_idx <= bus.tbl_next_index;
          hop_cnt <= hop_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_smallseg_g0_chain_walker.sv
// tb_smallseg_g0_chain_walker: directed plus random chain walks against an array-based table model.
module tb_smallseg_g0_chain_walker;
  localparam int MAX_HOPS = 16;
  localparam logic [10:0] NUL = 11'd2047;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  smallseg_g0_chain_walker_if bus ();
  smallseg_g0_chain_walker #(.MAX_HOPS(MAX_HOPS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // Entry layout: [125:22] key tuple, [21:11] ruleID, [10:0] next index.
  logic [170:0] mem [2048];
  logic [170:0] ref_mem [2048];
  always @(posedge clk) begin
    if (bus.tbl_we) mem[bus.tbl_search_index] <= bus.tbl_din;
    bus.tbl_match      <= mem[bus.tbl_search_index][125:22] == bus.tbl_tupleData;
    bus.tbl_ruleID     <= mem[bus.tbl_search_index][21:11];
    bus.tbl_next_index <= mem[bus.tbl_search_index][10:0];
  end
  int n_chk = 0, n_pass = 0, e_lat;
  logic [10:0] e_rule;
  logic e_hit, e_ovf;
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [170:0] mk(input logic [103:0] k, input logic [10:0] r, input logic [10:0] n);
    return {45'd0, k, r, n};
  endfunction
  function automatic logic [103:0] rnd_tuple();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[103:0];
  endfunction
  function automatic void model(input logic [103:0] t, input logic [10:0] head);
    logic [10:0] idx;
    logic [170:0] e;
    int reads;
    idx = head; reads = 0; e_rule = '1; e_hit = 1'b0; e_ovf = 1'b0;
    if (head != NUL)
      for (int i = 0; i < MAX_HOPS; i++) begin
        e = ref_mem[idx];
        reads++;
`ifdef CHAIN_EARLY_EXIT_EN
        if (e[125:22] == t) begin e_rule = e[21:11]; e_hit = 1'b1; break; end
`else
        if (e[125:22] == t && e[21:11] < e_rule) begin e_rule = e[21:11]; e_hit = 1'b1; end
`endif
        if (e[10:0] == NUL) break;
        if (i == MAX_HOPS - 1) e_ovf = 1'b1;
        else idx = e[10:0];
      end
    e_lat = 2 * reads + 1;
  endfunction
  task automatic wr(input logic [10:0] idx, input logic [170:0] d);
    bus.upd_valid = 1'b1; bus.upd_index = idx; bus.upd_data = d; #1;
    for (int n = 0; n < 50 && !bus.upd_ready; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    chk("wr_pulse", {bus.tbl_we, bus.tbl_search_index, bus.tbl_din}, {1'b1, idx, d});
    @(posedge clk); #1;
    ref_mem[idx] = d;
  endtask
  task automatic start_pkt(input logic [103:0] t, input logic [10:0] h);
    model(t, h);
    bus.pkt_valid = 1'b1; bus.pkt_tuple = t; bus.pkt_head = h; #1;
    for (int n = 0; n < 50 && !bus.pkt_ready; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0; bus.pkt_tuple = rnd_tuple(); bus.pkt_head = 11'($urandom);
  endtask
  task automatic finish_pkt(input string tag, input int hold);
    int lat;
    lat = 1;
    while (!bus.res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_res"}, {bus.res_match, bus.res_ruleID, bus.res_overflow}, {e_hit, e_rule, e_ovf});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {bus.res_valid, bus.res_match, bus.res_ruleID, bus.res_overflow, bus.pkt_ready, bus.upd_ready},
          {1'b1, e_hit, e_rule, e_ovf, 2'b00});
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_rel"}, {bus.res_valid, bus.pkt_ready, bus.upd_ready}, 3'b011);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [103:0] t;
    logic [170:0] d;
    logic [10:0] nx;
    int len, base, rb;
    logic lp;
    bus.pkt_valid = 1'b0; bus.pkt_tuple = '0; bus.pkt_head = '0;
    bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_data = '0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {bus.pkt_ready, bus.upd_ready, bus.res_valid, bus.res_match, bus.res_overflow, bus.tbl_we, bus.tbl_search_index}, '0);
    chk("rst_rule", bus.res_ruleID, 11'h7ff);
    rst_n = 1'b1; #1;
    chk("rst_rel_rdy", {bus.pkt_ready, bus.upd_ready}, 2'b11);
    t = rnd_tuple();
    wr(11'd5, mk(~t, 11'd100, 11'd9));
    wr(11'd9, mk(t, 11'd42, NUL));
    start_pkt(t, 11'd5);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst", {bus.res_valid, bus.tbl_we, bus.res_ruleID, bus.pkt_ready}, {2'b00, 11'h7ff, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("mid_rel_rdy", bus.pkt_ready, 1'b1);
    start_pkt(t, 11'd5);
    finish_pkt("two_hop", 0);
    t = rnd_tuple();
    wr(11'd3, mk(t, 11'd30, 11'd4));
    wr(11'd4, mk(t, 11'd12, NUL));
    start_pkt(t, 11'd3);
    finish_pkt("lowest", 0);
    wr(11'd7, mk(~t, 11'd5, 11'd7));
    start_pkt(t, 11'd7);
    finish_pkt("loop", 0);
    t = rnd_tuple();
    d = mk(t, 11'd77, NUL);
    bus.upd_valid = 1'b1; bus.upd_index = 11'd600; bus.upd_data = d;
    bus.pkt_valid = 1'b1; bus.pkt_tuple = t; bus.pkt_head = 11'd600; #1;
    chk("arb_rdy", {bus.pkt_ready, bus.upd_ready}, 2'b01);
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    chk("arb_we", {bus.tbl_we, bus.pkt_ready, bus.tbl_search_index, bus.tbl_din}, {2'b10, 11'd600, d});
    ref_mem[600] = d;
    model(t, 11'd600);
    @(posedge clk); #1;
    chk("arb_next", {bus.tbl_we, bus.pkt_ready}, 2'b01);
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
    finish_pkt("arb", 0);
    start_pkt(ref_mem[3][125:22], 11'd3);
    finish_pkt("stall", 10);
    start_pkt(rnd_tuple(), NUL);
    finish_pkt("null_head", 0);
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 5);
      base = $urandom_range(0, 2000);
      rb = $urandom_range(0, 2000);
      lp = $urandom_range(0, 4) == 0;
      t = rnd_tuple();
      for (int i = 0; i < len; i++) begin
        nx = (i == len - 1) ? (lp ? 11'(base) : NUL) : 11'(base + i + 1);
        wr(11'(base + i), mk($urandom_range(0, 1) ? t : rnd_tuple(), 11'(rb + i * 9), nx));
      end
      start_pkt(t, 11'(base));
      finish_pkt("rnd", 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
